// File: rtl/rv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv_pkg : shared RV32I constants, opcodes and the instruction-memory load  |
// | FSM state type.                       Rev 1.0 - initial release             |
// +----------------------------------------------------------------------------+
package rv_pkg;

  localparam logic [31:0] NOP       = 32'h00000013;

  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } load_state_e;

  // Bit 0 of a J-type offset is implicitly zero and is not encoded.
  function automatic logic [31:0] enc_jal(input logic [4:0] rd,
                                          input logic signed [20:0] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loadable_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loadable_if : host load / readback bus of the loadable instruction    |
// | memory.                               Rev 1.0 - initial release             |
// +----------------------------------------------------------------------------+
interface imem_loadable_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          host_start;
  logic [AW-1:0] host_base;
  logic [AW:0]   host_len;
  logic          host_wvalid;
  logic [31:0]   host_wdata;
  logic          host_wready;
  logic [AW-1:0] host_rd_addr;
  logic [31:0]   host_rd_data;
  logic          load_busy;
  logic          load_done;
  logic [AW:0]   load_count;

  modport master (
    output host_start, host_base, host_len, host_wvalid, host_wdata, host_rd_addr,
    input  host_wready, host_rd_data, load_busy, load_done, load_count
  );

  modport slave (
    input  host_start, host_base, host_len, host_wvalid, host_wdata, host_rd_addr,
    output host_wready, host_rd_data, load_busy, load_done, load_count
  );
endinterface
`default_nettype wire

// File: rtl/imem_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_load_ctrl : burst-load FSM with wrapping write pointer and beat count |
// |                                       Rev 1.0 - initial release             |
// +----------------------------------------------------------------------------+
module imem_load_ctrl
  import rv_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   len,
  input  logic          wvalid,
  output logic          wready,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count,
  output logic          idle,
  output logic          wr_en,
  output logic [AW-1:0] wr_idx
);

  load_state_e   state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW:0]   len_q, len_d;
  logic          busy_q, done_q, idle_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    len_d   = len_q;
    unique case (state_q)
      LD_IDLE: begin
        if (start) begin
          count_d = '0;
          len_d   = len;
          ptr_d   = ({1'b0, base} >= (AW+1)'(DEPTH)) ? '0 : base;
          state_d = (len == '0) ? LD_DONE : LD_LOAD;
        end
      end
      LD_LOAD: begin
        if (wvalid) begin
          count_d = count_q + 1'b1;
          ptr_d   = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
          if (count_d == len_q) state_d = LD_DONE;
        end
      end
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      ptr_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      len_q   <= len_d;
      busy_q  <= (state_d == LD_LOAD);
      done_q  <= (state_d == LD_DONE);
      idle_q  <= (state_d == LD_IDLE);
    end
  end

  assign wready = busy_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign idle   = idle_q;
  assign count  = count_q;
  assign wr_en  = busy_q & wvalid;
  assign wr_idx = ptr_q;

endmodule
`default_nettype wire

// File: rtl/imem_loadable.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loadable : host-loadable instruction memory with combinational fetch  |
// | and fault flagging.                   Rev 1.0 - initial release             |
// +----------------------------------------------------------------------------+
module imem_loadable
  import rv_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [31:0] NOP_WORD = NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     pc,
  output logic [31:0]     instr,
  output logic            fetch_valid,
  output logic            fetch_fault,
  imem_loadable_if.slave  host
);

  localparam int AW = $clog2(DEPTH);
  // Last word jumps back to word 0 so an unloaded memory spins on NOPs.
  localparam logic [31:0] JAL_LAST = enc_jal(5'd0, 21'(-(4 * (DEPTH - 1))));

  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   mem_d [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic          idle;
  logic [AW-1:0] fetch_idx;

  imem_load_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (host.host_start),
    .base   (host.host_base),
    .len    (host.host_len),
    .wvalid (host.host_wvalid),
    .wready (host.host_wready),
    .busy   (host.load_busy),
    .done   (host.load_done),
    .count  (host.load_count),
    .idle   (idle),
    .wr_en  (wr_en),
    .wr_idx (wr_idx)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = host.host_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= (i == DEPTH - 1) ? JAL_LAST : NOP_WORD;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign fetch_idx   = pc[AW+1:2];
  assign fetch_fault = (pc[1:0] != 2'b00) || (pc[31:2] >= 30'(DEPTH));
  assign instr       = fetch_fault ? NOP_WORD : mem_q[fetch_idx];
  assign fetch_valid = idle;

  assign host.host_rd_data = ({1'b0, host.host_rd_addr} >= (AW+1)'(DEPTH))
                             ? 32'h0 : mem_q[host.host_rd_addr];

endmodule
`default_nettype wire

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised instruction memory, the next generation of the fixed 16-word instruction RAM.
- Provides a combinational fetch port to the single-cycle core.
- Loads programs through a valid/ready burst interface driven by the logic-analyzer host, with auto-incrementing write pointer and load-status handshake.
- Flags misaligned/out-of-range fetches; field decode stays in a separate decoder.

Parameters:
- DEPTH, 16, number of 32-bit words; any value >= 4, need not be a power of two.
- NOP_WORD, 32'h00000013, fill value at reset and substitute instruction on fault (addi x0,x0,0).
- AW, $clog2(DEPTH), localparam, index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc  in  32  byte address of the current fetch
- instr  out  32  fetched instruction, NOP_WORD on fault
- fetch_valid  out  1  instr usable; core stalls when 0
- fetch_fault  out  1  pc[1:0]!=0 or (pc>>2)>=DEPTH
- host_start  in  1  start-load pulse, sampled in IDLE only
- host_base  in  AW  first word index written
- host_len  in  AW+1  number of words to load, 0..DEPTH
- host_wvalid  in  1  write beat valid
- host_wdata  in  32  write beat data
- host_wready  out  1  beat accepted when wvalid&wready
- host_rd_addr  in  AW  readback index
- host_rd_data  out  32  mem[host_rd_addr]; 0 if index>=DEPTH
- load_busy  out  1  FSM in LOAD
- load_done  out  1  one-cycle completion pulse
- load_count  out  AW+1  beats accepted in current/last load

Behaviour:
- Reset (async, wins over everything):
  - mem[0..DEPTH-2]=NOP_WORD.
  - mem[DEPTH-1]=jal x0 with offset -(4*(DEPTH-1)), encoded in RTL from DEPTH; DEPTH=16 gives 32'hFC5FF06F.
  - FSM=IDLE; ptr=0; load_count=0; load_done=0; host_wready=0; load_busy=0.
- FSM states IDLE, LOAD, DONE:
  - IDLE: host_start & host_len!=0 -> LOAD; ptr<=host_base; load_count<=0.
  - IDLE: host_start & host_len==0 -> DONE; no write; load_count<=0.
  - LOAD: host_wready=1. Each beat (wvalid&wready) writes mem[ptr] at posedge and increments load_count.
  - LOAD: ptr<=(ptr==DEPTH-1)?0:ptr+1, so the pointer wraps.
  - LOAD: the beat taking load_count to host_len (latched at start) -> DONE. Gaps in wvalid are legal and hold state.
  - DONE: load_done=1 for exactly one cycle -> IDLE. host_start is ignored in DONE and LOAD.
  - host_base>=DEPTH at start: ptr<=0.
- Fetch (combinational, zero latency):
  - index=pc[AW+1:2].
  - fetch_fault=1 if pc[1:0]!=0 or pc[31:2]>=DEPTH; instr=NOP_WORD on fault.
  - fetch_valid=0 whenever FSM!=IDLE, else 1. fetch_fault is still reported while busy.
- Write-to-read: a word written at edge N is visible on instr/host_rd_data after edge N (no bypass required).
- Reset mid-LOAD: load aborted, memory reinitialised to the reset image, no load_done pulse.
- load_count holds its final value until the next accepted host_start.

Decomposition:
- Shared package rv_pkg holds: NOP constant 32'h00000013; opcode localparams (OP_JAL=7'b1101111, OP_JALR, OP_BRANCH, etc.); a function encoding J-type from rd and a signed 21-bit offset.
- One sub-module, imem_load_ctrl, holds the FSM, ptr and load_count and emits write enable/index.
- Storage and fetch/fault logic stay in the top.

Test Plan:
- Reset, DEPTH=16 -> host_rd_data at addr 15 = 32'hFC5FF06F; addr 0..14 = 32'h00000013; fetch_valid=1.
- host_start, base=2, len=3, beats A,B,C with a 2-cycle wvalid gap -> mem[2..4]=A,B,C; load_busy for the whole load; fetch_valid=0 throughout; load_done pulses 1 cycle after C; load_count=3.
- base=14, len=4, DEPTH=16 -> writes land at 14,15,0,1 (wrap); load_count=4.
- len=0 -> load_done pulses next cycle; no memory change.
- pc=32'h2 -> fetch_fault=1, instr=NOP. pc=32'h40 (DEPTH=16) -> fault=1. pc=32'h3C -> fault=0, instr=jal.
- rst_n low after 2 of 5 beats -> state IDLE, memory equals reset image, no load_done pulse; host_start during LOAD ignored.
